dcache_refill_unit: RTL
=======================

# dcache_refill_unit

AXI3 read-burst initiator serving data cache refills: accepts one line-fill (8 × 32-bit) or uncached single-word read request from the dcache, issues the AR transaction, collects R beats into eight bank registers and pulses completion. It is the read-side counterpart of the dcache write buffer and drives the dcache's AXI AR/R channels toward the crossbar.

## Interface
- No parameters; line is fixed at 8 words × 32 bits, AXI ID fixed to 0.
- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- rreq  input  1  read request; held with paddr/is_uncached until rreq_recvd
- is_uncached  input  1  1: single-word read; 0: full line refill
- rreq_paddr  input  32  physical address of requested word
- rreq_recvd  output  1  request accepted (combinational, one cycle)
- rdone  output  1  one-cycle pulse: data in banks valid
- rerr  output  1  valid with rdone; OR of all rresp[1] over the transaction
- rdata_bank0 … rdata_bank7  output  32 each  returned line words, word i at byte offset 4·i
- busy  output  1  high in any state other than IDLE
- arid 4, araddr 32, arlen 4, arsize 3, arburst 2, arlock 2, arcache 4, arprot 3, arvalid 1  outputs  AXI3 AR channel
- arready  input  1
- rid 4, rdata 32, rresp 2, rlast 1, rvalid 1  inputs  AXI3 R channel
- rready  output  1

## Operation
- States: IDLE, ADDR, DATA, DONE.
- IDLE: rreq=1 → rreq_recvd=1 same cycle; latch paddr, is_uncached; clear err and beat counter; → ADDR.
- ADDR: arvalid=1, AR fields stable until arready sampled high; then → DATA.
  - Line: araddr={paddr[31:5],5'b0}, arlen=7, arsize=2, arburst=INCR(01).
  - Uncached: araddr=paddr (word aligned, paddr[1:0] forced 0), arlen=0, arsize=2, arburst=INCR.
  - arid=0, arlock=0, arcache=0, arprot=0 constant.
- DATA: rready=1. Each cycle rvalid=1: write rdata into bank[word_idx], word_idx ← word_idx+1 mod 8, beat_cnt++, err |= rresp[1]. Line start word_idx=0; uncached word_idx=paddr[4:2]. rlast=1 on accepted beat → DONE.
- Beats beyond arlen+1 before rlast: not written (beat_cnt saturates at arlen+1); completion still waits for rlast.
- rid ignored (single outstanding transaction, ID 0).
- DONE: rdone=1, rerr=err for one cycle; → IDLE. Banks hold until overwritten by next transaction's beats.
- rreq outside IDLE ignored (rreq_recvd=0); requester keeps rreq asserted.
- Uncached: only bank[paddr[4:2]] updated; other banks keep previous contents.

## Timing
- Reset values: arvalid, rready, rreq_recvd, rdone, rerr, busy = 0; araddr=0, arlen=0; all banks 0; state IDLE.
- Reset mid-transaction: next cycle IDLE, arvalid/rready low; outstanding beats afterward are not accepted (rready=0).
- rreq at cycle 0 → arvalid from cycle 1. arready at cycle n → rready from n+1. Last beat accepted at m → rdone at m+1, busy low at m+2, new rreq acceptable at m+2.
- Minimum line latency (arready at 1, rvalid continuous 2..9): rdone at cycle 10.
- rready continuously high in DATA; no R back-pressure.

## Configuration
- CRITICAL_WORD_FIRST_EN defined: line refills use arburst=WRAP(10), araddr={paddr[31:2],2'b0}, word_idx starts at paddr[4:2] and wraps; added output early_valid (1) / early_word (32) pulse one cycle after the first line beat is accepted carrying that beat (reset 0). Uncached path unchanged (no early pulse).
- Not defined: INCR from line base, word_idx starts at 0, no early_valid/early_word ports.

## Test plan
- Line refill, paddr=0x1FC0_0024, arready at cycle 1, beats 0xA0..0xA7 cycles 2..9, rlast at 9 → araddr=0x1FC0_0020, arlen=7, rdone at 10, bank i=0xA0+i, rerr=0.
- Uncached, paddr=0xBFAF_8008, rdata=0x1234_5678 rlast → arlen=0, araddr=0xBFAF_8008, only bank2=0x1234_5678, others unchanged.
- AR back-pressure: arready low 5 cycles → arvalid and araddr stable all 5, rready stays 0; rvalid gaps in DATA → correct bank order, rdone one cycle after rlast.
- rresp=2'b10 on beat 3 only → rerr=1 with rdone; next clean transaction rerr=0.
- rreq held during DATA, rst pulsed at beat 4 → rreq_recvd=0 before rst, after rst IDLE with banks 0, rreq_recvd=1 next cycle.
- With CRITICAL_WORD_FIRST_EN, paddr=0x0000_0054 → arburst=2, araddr=0x54, beats 0xB0..0xB7 land bank5,6,7,0..4, early_word=0xB0 one cycle after first beat.

Source files
------------

// File: rtl/dcache_refill_unit.sv
// AXI3 read-burst initiator for dcache line refills (8 x 32-bit) and uncached single-word reads.
// Optional define CRITICAL_WORD_FIRST_EN: wrapping line bursts from the requested word plus an early-word pulse.
module dcache_refill_unit (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_rreq,
  input  logic        i_is_uncached,
  input  logic [31:0] i_rreq_paddr,
  output logic        o_rreq_recvd,
  output logic        o_rdone,
  output logic        o_rerr,
  output logic [31:0] o_rdata_bank0,
  output logic [31:0] o_rdata_bank1,
  output logic [31:0] o_rdata_bank2,
  output logic [31:0] o_rdata_bank3,
  output logic [31:0] o_rdata_bank4,
  output logic [31:0] o_rdata_bank5,
  output logic [31:0] o_rdata_bank6,
  output logic [31:0] o_rdata_bank7,
  output logic        o_busy,
  output logic [3:0]  o_arid,
  output logic [31:0] o_araddr,
  output logic [3:0]  o_arlen,
  output logic [2:0]  o_arsize,
  output logic [1:0]  o_arburst,
  output logic [1:0]  o_arlock,
  output logic [3:0]  o_arcache,
  output logic [2:0]  o_arprot,
  output logic        o_arvalid,
  input  logic        i_arready,
  input  logic [3:0]  i_rid,
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_rresp,
  input  logic        i_rlast,
  input  logic        i_rvalid,
`ifdef CRITICAL_WORD_FIRST_EN
  output logic        o_early_valid,
  output logic [31:0] o_early_word,
`endif
  output logic        o_rready
);

  localparam int unsigned NUM_WORDS = 8;
  localparam logic [1:0] BURST_INCR = 2'b01;
`ifdef CRITICAL_WORD_FIRST_EN
  localparam logic [1:0] BURST_WRAP = 2'b10;
`endif

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;

  state_t      r_state;
  state_t      w_next;
  logic        w_accept;
  logic        w_beat;
  logic [31:0] r_araddr;
  logic [3:0]  r_arlen;
  logic [1:0]  r_arburst;
  logic        r_uncached;
  logic        r_err;
  logic [3:0]  r_beat_cnt;
  logic [2:0]  r_word_idx;
  logic [31:0] r_bank [NUM_WORDS];
  logic        w_unused;

  // Single outstanding ID-0 transaction, so rid is never inspected.
  assign w_unused = ^{i_rid, i_rresp[0], i_rreq_paddr[1:0]};

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_accept     = 1'b0;
    w_beat       = 1'b0;
    o_rreq_recvd = 1'b0;
    o_arvalid    = 1'b0;
    o_rready     = 1'b0;
    o_rdone      = 1'b0;
    o_rerr       = 1'b0;
    o_busy       = 1'b1;
    case (r_state)
      S_IDLE: begin
        o_busy = 1'b0;
        if (i_rreq) begin
          o_rreq_recvd = 1'b1;
          w_accept     = 1'b1;
          w_next       = S_ADDR;
        end
      end
      S_ADDR: begin
        o_arvalid = 1'b1;
        if (i_arready) w_next = S_DATA;
      end
      S_DATA: begin
        o_rready = 1'b1;
        if (i_rvalid) begin
          w_beat = 1'b1;
          if (i_rlast) w_next = S_DONE;
        end
      end
      S_DONE: begin
        o_rdone = 1'b1;
        o_rerr  = r_err;
        w_next  = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Request latch, beat bookkeeping and bank capture.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_araddr   <= '0;
      r_arlen    <= '0;
      r_arburst  <= BURST_INCR;
      r_uncached <= 1'b0;
      r_err      <= 1'b0;
      r_beat_cnt <= '0;
      r_word_idx <= '0;
      for (int i = 0; i < NUM_WORDS; i++) r_bank[i] <= '0;
    end else begin
      if (w_accept) begin
        r_uncached <= i_is_uncached;
        r_err      <= 1'b0;
        r_beat_cnt <= '0;
        if (i_is_uncached) begin
          r_araddr   <= {i_rreq_paddr[31:2], 2'b00};
          r_arlen    <= 4'd0;
          r_arburst  <= BURST_INCR;
          r_word_idx <= i_rreq_paddr[4:2];
        end else begin
          r_arlen    <= 4'd7;
`ifdef CRITICAL_WORD_FIRST_EN
          r_araddr   <= {i_rreq_paddr[31:2], 2'b00};
          r_arburst  <= BURST_WRAP;
          r_word_idx <= i_rreq_paddr[4:2];
`else
          r_araddr   <= {i_rreq_paddr[31:5], 5'b0};
          r_arburst  <= BURST_INCR;
          r_word_idx <= 3'd0;
`endif
        end
      end
      if (w_beat) begin
        r_err <= r_err | i_rresp[1];
        // Beats past arlen+1 are dropped; completion still waits for rlast.
        if (r_beat_cnt <= {1'b0, r_arlen[2:0]}) begin
          r_bank[r_word_idx] <= i_rdata;
          r_word_idx         <= r_word_idx + 3'd1;
          r_beat_cnt         <= r_beat_cnt + 4'd1;
        end
      end
    end
  end

`ifdef CRITICAL_WORD_FIRST_EN
  logic        r_early_valid;
  logic [31:0] r_early_word;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_early_valid <= 1'b0;
      r_early_word  <= '0;
    end else begin
      r_early_valid <= w_beat && !r_uncached && (r_beat_cnt == 4'd0);
      if (w_beat && (r_beat_cnt == 4'd0)) r_early_word <= i_rdata;
    end
  end

  assign o_early_valid = r_early_valid;
  assign o_early_word  = r_early_word;
`endif

  assign o_arid    = 4'd0;
  assign o_araddr  = r_araddr;
  assign o_arlen   = r_arlen;
  assign o_arsize  = 3'd2;
  assign o_arburst = r_arburst;
  assign o_arlock  = 2'd0;
  assign o_arcache = 4'd0;
  assign o_arprot  = 3'd0;

  assign o_rdata_bank0 = r_bank[0];
  assign o_rdata_bank1 = r_bank[1];
  assign o_rdata_bank2 = r_bank[2];
  assign o_rdata_bank3 = r_bank[3];
  assign o_rdata_bank4 = r_bank[4];
  assign o_rdata_bank5 = r_bank[5];
  assign o_rdata_bank6 = r_bank[6];
  assign o_rdata_bank7 = r_bank[7];

endmodule
